// File: rtl/regfile_wb_scoreboard.sv
// Writeback decoder and busy scoreboard for the register file.
// Produces a registered one-hot load enable and stalls issue on RAW/WAW hazards.
module regfile_wb_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int NREGS    = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dst,
  input  logic [ADDR_W-1:0] iss_src_a,
  input  logic              iss_use_a,
  input  logic [ADDR_W-1:0] iss_src_b,
  input  logic              iss_use_b,
  output logic              stall,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dst,
  output logic [NREGS-1:0]  ld_en,
  output logic [NREGS-1:0]  busy,
  output logic [ADDR_W:0]   busy_cnt,
  output logic              wb_err
);

  logic [NREGS-1:0] ld_en_q, ld_en_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  busy_cnt_q, busy_cnt_d;
  logic             wb_err_q, wb_err_d;
  logic             iss_accept;
  logic             iss_is_zero;
  logic             wb_is_zero;

  function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] v);
    logic [ADDR_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  assign iss_is_zero = (ZERO_REG != 0) && (iss_dst == '0);
  assign wb_is_zero  = (ZERO_REG != 0) && (wb_dst == '0);

  // Hazard check sees registered busy only; a writeback this cycle does not unblock issue.
  always_comb begin
    stall = iss_valid & ((iss_use_a & busy_q[iss_src_a]) |
                         (iss_use_b & busy_q[iss_src_b]) |
                         busy_q[iss_dst]);
  end

  assign iss_accept = iss_valid & ~stall;

  always_comb begin
    busy_d   = busy_q;
    ld_en_d  = '0;
    wb_err_d = wb_err_q;
    if (wb_valid && !wb_is_zero) begin
      busy_d[wb_dst]  = 1'b0;
      ld_en_d[wb_dst] = 1'b1;
      if (!busy_q[wb_dst]) begin
        wb_err_d = 1'b1;
      end
    end
    if (iss_accept && !iss_is_zero) begin
      busy_d[iss_dst] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
    busy_cnt_d = popcount(busy_d);
  end

  // Register stage: all scoreboard state and the load enable update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_en_q    <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      ld_en_q    <= ld_en_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign ld_en    = ld_en_q;
  assign busy     = busy_q;
  assign busy_cnt = busy_cnt_q;
  assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed bench for regfile_wb_scoreboard with hand-computed expectations.
module tb_regfile_wb_scoreboard;

  logic        clk;
  logic        reset;
  logic        iss_valid;
  logic [4:0]  iss_dst;
  logic [4:0]  iss_src_a;
  logic        iss_use_a;
  logic [4:0]  iss_src_b;
  logic        iss_use_b;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_dst;
  logic [31:0] ld_en;
  logic [31:0] busy;
  logic [5:0]  busy_cnt;
  logic        wb_err;

  int checks;
  int errors;

  regfile_wb_scoreboard #(.ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_dst(iss_dst),
    .iss_src_a(iss_src_a), .iss_use_a(iss_use_a),
    .iss_src_b(iss_src_b), .iss_use_b(iss_use_b),
    .stall(stall), .wb_valid(wb_valid), .wb_dst(wb_dst),
    .ld_en(ld_en), .busy(busy), .busy_cnt(busy_cnt), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_dst = '0; iss_src_a = '0; iss_use_a = 1'b0;
    iss_src_b = '0; iss_use_b = 1'b0; wb_valid = 1'b0; wb_dst = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    step(); step();
    reset = 1'b0;
    step();
    checks++; if (ld_en !== 32'h0) begin errors++; $display("FAIL reset_ld_en got %h want %h", ld_en, 32'h0); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h want %h", busy, 32'h0); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_busy_cnt got %0d want 0", busy_cnt); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_wb_err got %b want 0", wb_err); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
  endtask

  task automatic test_raw();
    iss_valid = 1'b1; iss_dst = 5'd5;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_first_stall got %b want 0", stall); end
    step();
    checks++; if (busy !== 32'h20) begin errors++; $display("FAIL raw_busy5 got %h want %h", busy, 32'h20); end
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL raw_cnt1 got %0d want 1", busy_cnt); end
    iss_dst = 5'd6; iss_use_a = 1'b1; iss_src_a = 5'd5;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall got %b want 1", stall); end
    step();
    checks++; if (busy !== 32'h20) begin errors++; $display("FAIL raw_held got %h want %h", busy, 32'h20); end
    wb_valid = 1'b1; wb_dst = 5'd5;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_no_bypass got %b want 1", stall); end
    step();
    checks++; if (ld_en !== 32'h20) begin errors++; $display("FAIL raw_ld_en got %h want %h", ld_en, 32'h20); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL raw_busy_clr got %h want %h", busy, 32'h0); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_unstall got %b want 0", stall); end
    wb_valid = 1'b0;
    step();
    checks++; if (busy !== 32'h40) begin errors++; $display("FAIL raw_accept got %h want %h", busy, 32'h40); end
    checks++; if (ld_en !== 32'h0) begin errors++; $display("FAIL raw_ld_off got %h want %h", ld_en, 32'h0); end
    idle_inputs();
    wb_valid = 1'b1; wb_dst = 5'd6;
    step();
    wb_valid = 1'b0;
    step();
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL raw_cleanup got %h want %h", busy, 32'h0); end
  endtask

  task automatic test_waw();
    iss_valid = 1'b1; iss_dst = 5'd7;
    step();
    checks++; if (busy !== 32'h80) begin errors++; $display("FAIL waw_busy7 got %h want %h", busy, 32'h80); end
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall got %b want 1", stall); end
    step();
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL waw_cnt got %0d want 1", busy_cnt); end
    wb_valid = 1'b1; wb_dst = 5'd7;
    step();
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL waw_clr got %h want %h", busy, 32'h0); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_unstall got %b want 0", stall); end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    iss_valid = 1'b1; iss_dst = 5'd9;
    step();
    iss_dst = 5'd10; wb_valid = 1'b1; wb_dst = 5'd9;
    step();
    checks++; if (busy !== 32'h400) begin errors++; $display("FAIL b2b_busy got %h want %h", busy, 32'h400); end
    checks++; if (ld_en !== 32'h200) begin errors++; $display("FAIL b2b_ld_en got %h want %h", ld_en, 32'h200); end
    iss_valid = 1'b0; wb_dst = 5'd10;
    step();
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL b2b_clr got %h want %h", busy, 32'h0); end
    idle_inputs();
    step();
  endtask

  task automatic test_zero_reg();
    iss_valid = 1'b1; iss_dst = 5'd0; wb_valid = 1'b1; wb_dst = 5'd0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got %b want 0", stall); end
    step();
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL zero_busy got %h want %h", busy, 32'h0); end
    checks++; if (ld_en !== 32'h0) begin errors++; $display("FAIL zero_ld_en got %h want %h", ld_en, 32'h0); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL zero_wb_err got %b want 0", wb_err); end
    idle_inputs();
    step();
  endtask

  task automatic test_wb_err();
    wb_valid = 1'b1; wb_dst = 5'd31;
    step();
    checks++; if (ld_en !== 32'h8000_0000) begin errors++; $display("FAIL err_ld_en got %h want %h", ld_en, 32'h8000_0000); end
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", wb_err); end
    wb_valid = 1'b0;
    step(); step();
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", wb_err); end
    checks++; if (ld_en !== 32'h0) begin errors++; $display("FAIL err_ld_off got %h want %h", ld_en, 32'h0); end
  endtask

  task automatic test_fill_reset();
    for (int r = 1; r < 32; r++) begin
      iss_valid = 1'b1; iss_dst = 5'(r);
      step();
    end
    iss_valid = 1'b0;
    checks++; if (busy !== 32'hFFFF_FFFE) begin errors++; $display("FAIL fill_busy got %h want %h", busy, 32'hFFFF_FFFE); end
    checks++; if (busy_cnt !== 6'd31) begin errors++; $display("FAIL fill_cnt got %0d want 31", busy_cnt); end
    iss_valid = 1'b1; iss_dst = 5'd0; iss_use_b = 1'b1; iss_src_b = 5'd12;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fill_src_b_stall got %b want 1", stall); end
    idle_inputs();
    wb_valid = 1'b1; wb_dst = 5'd3; reset = 1'b1;
    step();
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL rst_busy got %h want %h", busy, 32'h0); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", busy_cnt); end
    checks++; if (ld_en !== 32'h0) begin errors++; $display("FAIL rst_ld_en got %h want %h", ld_en, 32'h0); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL rst_wb_err got %b want 0", wb_err); end
    reset = 1'b0; wb_valid = 1'b0;
    step();
    checks++; if (ld_en !== 32'h0) begin errors++; $display("FAIL rst_no_ld got %h want %h", ld_en, 32'h0); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL rst_busy_after got %h want %h", busy, 32'h0); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_raw();
    test_waw();
    test_back_to_back();
    test_zero_reg();
    test_wb_err();
    test_fill_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
